// File: rtl/mult_pkg.sv
// Shared definitions for the signed 8x8 multiplier controller and its helpers.
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 14;
  localparam int RES_W  = 16;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Most negative operand; its magnitude is 8'h80 and only fits unsigned.
  localparam logic [OP_W-1:0]  NEG_MIN        = 8'h80;
  // -128 * -128 = +16384 overflows the 14-bit datapath product.
  localparam logic [RES_W-1:0] SPECIAL_RESULT = 16'h4000;

  // Widen the unsigned product and negate it unless it is zero, so that
  // a zero product never turns into a negative-signed zero pattern.
  function automatic logic [RES_W-1:0] apply_sign(input logic neg,
                                                  input logic [PROD_W-1:0] prod);
    logic [RES_W-1:0] ext;
    ext = {{(RES_W-PROD_W){1'b0}}, prod};
    return (neg && (prod != '0)) ? (~ext + {{(RES_W-1){1'b0}}, 1'b1}) : ext;
  endfunction

endpackage

// File: rtl/sign_magnitude.sv
// Splits an 8-bit two's-complement value into magnitude and sign.
// -128 maps to magnitude 8'h80, read as unsigned by the datapath.
module sign_magnitude
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] value,
  output logic [OP_W-1:0] mag,
  output logic            sign
);

  assign sign = value[OP_W-1];
  assign mag  = sign ? (~value + {{(OP_W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/signed_mult_ctrl.sv
// Sequencing controller that turns the unsigned shift-add datapath into a
// signed 8x8 multiplier with a start/busy/done handshake and a run watchdog.
module signed_mult_ctrl
  import mult_pkg::*;
#(
  parameter int MAX_RUN = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OP_W-1:0]      op_a,
  input  logic [OP_W-1:0]      op_b,
  output logic                 busy,
  output logic                 done,
  output logic [RES_W-1:0]     result,
  output logic                 err,
  output logic [OP_W-1:0]      dp_multiplier,
  output logic [OP_W-1:0]      dp_multiplicand,
  output logic                 dp_load,
  output logic                 dp_psel,
  output logic                 dp_reg_en,
  output logic                 dp_shift_en,
  input  logic                 dp_zflag,
  input  logic [PROD_W-1:0]    dp_product
);

  localparam int               CNT_W    = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_RUN - 1);

  state_t             state_reg;
  logic               neg_reg;
  logic               special_reg;
  logic [CNT_W-1:0]   run_cnt_reg;
  logic [OP_W-1:0]    mag_a_reg;
  logic [OP_W-1:0]    mag_b_reg;
  logic               done_reg;
  logic               err_reg;
  logic [RES_W-1:0]   result_reg;

  logic [OP_W-1:0]    mag_a;
  logic [OP_W-1:0]    mag_b;
  logic               sign_a;
  logic               sign_b;

  sign_magnitude u_sm_a (
    .value (op_a),
    .mag   (mag_a),
    .sign  (sign_a)
  );

  sign_magnitude u_sm_b (
    .value (op_b),
    .mag   (mag_b),
    .sign  (sign_b)
  );

  // Sequencer: captures operands on accept, loads, runs until the
  // multiplicand is exhausted (or the watchdog fires), then signs the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      neg_reg     <= 1'b0;
      special_reg <= 1'b0;
      run_cnt_reg <= '0;
      mag_a_reg   <= '0;
      mag_b_reg   <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      result_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mag_a_reg   <= mag_a;
            mag_b_reg   <= mag_b;
            neg_reg     <= sign_a ^ sign_b;
            special_reg <= (op_a == NEG_MIN) && (op_b == NEG_MIN);
            err_reg     <= 1'b0;
            state_reg   <= LOAD;
          end
        end
        LOAD: begin
          run_cnt_reg <= '0;
          state_reg   <= RUN;
        end
        RUN: begin
          if (dp_zflag) begin
            state_reg <= FIX;
          end else if (run_cnt_reg == RUN_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= FIX;
          end else begin
            run_cnt_reg <= run_cnt_reg + 1'b1;
          end
        end
        FIX: begin
          result_reg <= special_reg ? SPECIAL_RESULT : apply_sign(neg_reg, dp_product);
          done_reg   <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Datapath strobes decode from state; RUN strobes also follow zflag so
  // the last shift happens in the same cycle the multiplicand empties.
  always_comb begin
    dp_load     = (state_reg == LOAD);
    dp_psel     = (state_reg == RUN) && !dp_zflag;
    dp_reg_en   = (state_reg == LOAD) || ((state_reg == RUN) && !dp_zflag);
    dp_shift_en = (state_reg == RUN) && !dp_zflag;
  end

  assign busy            = (state_reg != IDLE);
  assign done            = done_reg;
  assign err             = err_reg;
  assign result          = result_reg;
  assign dp_multiplier   = mag_a_reg;
  assign dp_multiplicand = mag_b_reg;

endmodule

// File: tb/tb_signed_mult_ctrl.sv
// Testbench: controller plus a behavioural unsigned shift-add datapath,
// checked against plain signed arithmetic and a bit-length latency model.
module tb_signed_mult_ctrl;

  localparam int MAX_RUN = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  op_a = 8'd0;
  logic [7:0]  op_b = 8'd0;
  logic        busy, done, err;
  logic [15:0] result;
  logic [7:0]  dp_multiplier, dp_multiplicand;
  logic        dp_load, dp_psel, dp_reg_en, dp_shift_en;
  logic        dp_zflag;
  logic [13:0] dp_product;
  logic        force_z = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  signed_mult_ctrl #(.MAX_RUN(MAX_RUN)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .op_a            (op_a),
    .op_b            (op_b),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .err             (err),
    .dp_multiplier   (dp_multiplier),
    .dp_multiplicand (dp_multiplicand),
    .dp_load         (dp_load),
    .dp_psel         (dp_psel),
    .dp_reg_en       (dp_reg_en),
    .dp_shift_en     (dp_shift_en),
    .dp_zflag        (dp_zflag),
    .dp_product      (dp_product)
  );

  // Behavioural unsigned shift-add datapath.
  logic [7:0]  dpm_cand;
  logic [13:0] dpm_plier;
  logic [13:0] dpm_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpm_cand  <= '0;
      dpm_plier <= '0;
      dpm_prod  <= '0;
    end else begin
      if (dp_load) begin
        dpm_cand  <= dp_multiplicand;
        dpm_plier <= {6'd0, dp_multiplier};
      end else if (dp_shift_en) begin
        dpm_cand  <= dpm_cand >> 1;
        dpm_plier <= dpm_plier << 1;
      end
      if (dp_reg_en)
        dpm_prod <= dp_psel ? (dpm_prod + (dpm_cand[0] ? dpm_plier : 14'd0)) : 14'd0;
    end
  end

  assign dp_zflag   = force_z ? 1'b0 : (dpm_cand == 8'd0);
  assign dp_product = dpm_prod;

  // Reference: ordinary signed multiplication, kept to 16 bits.
  function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Reference latency: 3 edges plus one per significant bit of |b|.
  function automatic int ref_lat(input logic [7:0] b);
    int m;
    int lat;
    m = int'($signed(b));
    if (m < 0) m = -m;
    lat = 3;
    while (m > 0) begin
      lat++;
      m = m >> 1;
    end
    return lat;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one multiply from IDLE; return edges from accept to done-high
  // and the number of cycles with dp_shift_en high.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int edges, output int shifts, output bit timed_out);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 8'($urandom);
    op_b  = 8'($urandom);
    edges = 0;
    shifts = 0;
    timed_out = 1'b1;
    while (timed_out && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (dp_shift_en) shifts++;
      if (done) timed_out = 1'b0;
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    int  edges, shifts;
    bit  to;
    run_op(a, b, edges, shifts, to);
    $display("op %s a=%0d b=%0d result=%0h err=%0b edges=%0d shifts=%0d",
             tag, $signed(a), $signed(b), result, err, edges, shifts);
    chk({tag, "_timeout"}, 32'(to), 32'd0);
    chk({tag, "_result"},  32'(result), 32'(ref_mult(a, b)));
    chk({tag, "_err"},     32'(err), 32'd0);
    chk({tag, "_latency"}, 32'(edges), 32'(ref_lat(b)));
    chk({tag, "_shifts"},  32'(shifts), 32'(ref_lat(b) - 3));
    chk({tag, "_busy"},    32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int edges, shifts;
    bit to;
    logic [7:0] ra, rb;

    // Reset state
    #12;
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_strobes", 32'({dp_load, dp_psel, dp_reg_en, dp_shift_en}), 32'd0);
    chk("rst_ops",    32'({dp_multiplier, dp_multiplicand}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    check_op("d_3xm5", 8'd3, 8'hFB);
    chk("d_3xm5_const", 32'(result), 32'h0000FFF1);
    check_op("d_m7x0", 8'hF9, 8'd0);
    chk("d_m7x0_const", 32'(result), 32'h00000000);
    check_op("d_minxmin", 8'h80, 8'h80);
    chk("d_minxmin_const", 32'(result), 32'h00004000);
    check_op("d_minx127", 8'h80, 8'h7F);
    chk("d_minx127_const", 32'(result), 32'h0000C080);
    check_op("d_0xm1", 8'd0, 8'hFF);

    // Randomized operands
    for (int i = 0; i < 24; i++)
      check_op("rnd", 8'($urandom), 8'($urandom));

    // Start held high with operands churning while busy
    @(negedge clk);
    op_a  = 8'($urandom);
    op_b  = 8'($urandom);
    start = 1'b1;
    ra = op_a;
    rb = op_b;
    for (int i = 0; i < 4; i++) begin
      int cyc;
      bit got;
      cyc = 0;
      got = 1'b0;
      @(posedge clk);
      while (cyc < 40 && !got) begin
        @(negedge clk);
        cyc++;
        if (done) got = 1'b1;
        else begin
          op_a = 8'($urandom);
          op_b = 8'($urandom);
        end
      end
      $display("op held a=%0d b=%0d result=%0h edges=%0d", $signed(ra), $signed(rb), result, cyc - 1);
      chk("held_timeout", 32'(got), 32'd1);
      chk("held_result",  32'(result), 32'(ref_mult(ra, rb)));
      chk("held_latency", 32'(cyc - 1), 32'(ref_lat(rb)));
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      ra = op_a;
      rb = op_b;
    end
    start = 1'b0;
    @(negedge clk);
    chk("held_release_busy", 32'(busy), 32'd0);

    // Reset pulsed in the middle of RUN
    check_op("pre_rst", 8'd9, 8'd7);
    @(negedge clk);
    op_a  = 8'd3;
    op_b  = 8'h9C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrun_shift", 32'(dp_shift_en), 32'd1);
    rst_n = 1'b0;
    #1;
    $display("op reset_midrun busy=%0b result=%0h", busy, result);
    chk("midrst_busy",    32'(busy), 32'd0);
    chk("midrst_strobes", 32'({dp_load, dp_psel, dp_reg_en, dp_shift_en}), 32'd0);
    chk("midrst_result",  32'(result), 32'd0);
    chk("midrst_done",    32'(done), 32'd0);
    chk("midrst_ops",     32'({dp_multiplier, dp_multiplicand}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_op("post_rst", 8'd12, 8'd10);
    chk("post_rst_const", 32'(result), 32'h00000078);

    // Watchdog: datapath never reports an empty multiplicand
    force_z = 1'b1;
    run_op(8'd5, 8'd3, edges, shifts, to);
    $display("op watchdog a=5 b=3 err=%0b edges=%0d shifts=%0d", err, edges, shifts);
    chk("wd_timeout", 32'(to), 32'd0);
    chk("wd_err",     32'(err), 32'd1);
    chk("wd_latency", 32'(edges), 32'(MAX_RUN + 2));
    chk("wd_shifts",  32'(shifts), 32'(MAX_RUN));
    force_z = 1'b0;
    check_op("after_wd", 8'hF6, 8'd21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
